// File: rtl/peri_arb.sv
// Two-master round-robin arbiter for the slow peripheral port.
// Handles one transaction at a time, with a strobe-low gap between transactions and a timeout abort.
module peri_arb #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdat,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdat,
    output logic        m1_err,
    output logic        p_regw,
    output logic        p_regr,
    output logic [31:0] p_adr,
    output logic [31:0] p_wdata,
    input  logic        p_ack,
    input  logic [31:0] p_rdat,
    output logic        busy
);

    // state | meaning
    // IDLE  | strobes low, waiting for a request
    // WAIT  | strobe held with latched command, waiting for p_ack or timeout
    // RESP  | strobes low, one-cycle ack to the granted master
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        rr, rr_nxt;
    logic        lat_id, lat_id_nxt;
    logic        lat_we, lat_we_nxt;
    logic [31:0] lat_adr, lat_adr_nxt;
    logic [31:0] lat_wdata, lat_wdata_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [31:0] rsp_rdat, rsp_rdat_nxt;
    logic        rsp_err, rsp_err_nxt;
    logic        gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= 1'b0;
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_adr   <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            rsp_rdat  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr        <= rr_nxt;
            lat_id    <= lat_id_nxt;
            lat_we    <= lat_we_nxt;
            lat_adr   <= lat_adr_nxt;
            lat_wdata <= lat_wdata_nxt;
            cnt       <= cnt_nxt;
            rsp_rdat  <= rsp_rdat_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rr_nxt        = rr;
        lat_id_nxt    = lat_id;
        lat_we_nxt    = lat_we;
        lat_adr_nxt   = lat_adr;
        lat_wdata_nxt = lat_wdata;
        cnt_nxt       = cnt;
        rsp_rdat_nxt  = rsp_rdat;
        rsp_err_nxt   = rsp_err;
        // m0 wins when it is alone or when the pointer favours it
        gnt           = !(m0_req && (!m1_req || !rr));
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    lat_id_nxt    = gnt;
                    lat_we_nxt    = gnt ? m1_we    : m0_we;
                    lat_adr_nxt   = gnt ? m1_adr   : m0_adr;
                    lat_wdata_nxt = gnt ? m1_wdata : m0_wdata;
                    rr_nxt        = !gnt;
                    cnt_nxt       = '0;
                    state_nxt     = WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt + 8'd1;
                if (p_ack) begin
                    rsp_rdat_nxt = lat_we ? 32'd0 : p_rdat;
                    rsp_err_nxt  = 1'b0;
                    state_nxt    = RESP;
                end else if (cnt == TO_LAST) begin
                    rsp_rdat_nxt = 32'd0;
                    rsp_err_nxt  = 1'b1;
                    state_nxt    = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign p_regw  = (state == WAIT) &&  lat_we;
    assign p_regr  = (state == WAIT) && !lat_we;
    assign p_adr   = (state == WAIT) ? lat_adr   : 32'd0;
    assign p_wdata = (state == WAIT) ? lat_wdata : 32'd0;
    assign busy    = (state != IDLE);

    assign m0_ack  = (state == RESP) && !lat_id;
    assign m1_ack  = (state == RESP) &&  lat_id;
    assign m0_rdat = m0_ack ? rsp_rdat : 32'd0;
    assign m1_rdat = m1_ack ? rsp_rdat : 32'd0;
    assign m0_err  = m0_ack && rsp_err;
    assign m1_err  = m1_ack && rsp_err;

endmodule

// File: tb/tb_peri_arb.sv
// Directed bench for peri_arb: two instances (TIMEOUT=16 and TIMEOUT=4), each with a
// peripheral that acks in the 4th strobe-high cycle, plus a console capture on address 0x13000.
module tb_peri_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_adr = '0, m0_wdata = '0, m1_adr = '0, m1_wdata = '0;

    logic        m0_ack, m0_err, m1_ack, m1_err, p_regw, p_regr, p_ack, busy;
    logic [31:0] m0_rdat, m1_rdat, p_adr, p_wdata, p_rdat;
    logic        m0_ack4, m0_err4, m1_ack4, m1_err4, p_regw4, p_regr4, p_ack4, busy4;
    logic [31:0] m0_rdat4, m1_rdat4, p_adr4, p_wdata4, p_rdat4;

    logic        pen = 1'b1, pen4 = 1'b1, force_ack = 1'b0;
    logic [7:0]  scnt = '0, scnt4 = '0;
    logic [7:0]  con_chr = '0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    peri_arb #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdat(m0_rdat), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdat(m1_rdat), .m1_err(m1_err),
        .p_regw(p_regw), .p_regr(p_regr), .p_adr(p_adr), .p_wdata(p_wdata),
        .p_ack(p_ack), .p_rdat(p_rdat), .busy(busy)
    );

    peri_arb #(.TIMEOUT(4)) dut4 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack4), .m0_rdat(m0_rdat4), .m0_err(m0_err4),
        .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack4), .m1_rdat(m1_rdat4), .m1_err(m1_err4),
        .p_regw(p_regw4), .p_regr(p_regr4), .p_adr(p_adr4), .p_wdata(p_wdata4),
        .p_ack(p_ack4), .p_rdat(p_rdat4), .busy(busy4)
    );

    // peripheral: ack on the 4th consecutive strobe-high cycle
    always @(posedge clk) begin
        scnt  <= (p_regw  || p_regr)  ? scnt  + 8'd1 : 8'd0;
        scnt4 <= (p_regw4 || p_regr4) ? scnt4 + 8'd1 : 8'd0;
        if (p_ack && p_regw && p_adr == 32'h0001_3000)
            con_chr <= p_wdata[7:0];
    end

    assign p_ack   = (pen && (p_regw || p_regr) && scnt == 8'd3) || force_ack;
    assign p_ack4  = pen4 && (p_regw4 || p_regr4) && scnt4 == 8'd3;
    assign p_rdat  = p_ack  ? 32'h1234_5678 : 32'hA5A5_A5A5;
    assign p_rdat4 = p_ack4 ? 32'h1234_5678 : 32'hA5A5_A5A5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_regw"},  {31'd0, p_regw}, 32'd0);
        check({tag, "_regr"},  {31'd0, p_regr}, 32'd0);
        check({tag, "_adr"},   p_adr, 32'd0);
        check({tag, "_wdata"}, p_wdata, 32'd0);
        check({tag, "_acks"},  {30'd0, m1_ack, m0_ack}, 32'd0);
        check({tag, "_errs"},  {30'd0, m1_err, m0_err}, 32'd0);
        check({tag, "_rdat0"}, m0_rdat, 32'd0);
        check({tag, "_rdat1"}, m1_rdat, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        check_quiet("rst");

        // single m0 read
        step(); m0_req = 1; m0_we = 0; m0_adr = 32'h100;              // cycle 0
        check("rd_c0_regr", {31'd0, p_regr}, 32'd0);
        step();                                                       // cycle 1
        check("rd_c1_regr", {31'd0, p_regr}, 32'd1);
        check("rd_c1_regw", {31'd0, p_regw}, 32'd0);
        check("rd_c1_adr",  p_adr, 32'h100);
        check("rd_c1_busy", {31'd0, busy}, 32'd1);
        repeat (3) step();                                            // cycle 4
        check("rd_c4_pack", {31'd0, p_ack}, 32'd1);
        check("rd_c4_ack",  {31'd0, m0_ack}, 32'd0);
        step();                                                       // cycle 5
        check("rd_c5_ack",  {31'd0, m0_ack}, 32'd1);
        check("rd_c5_rdat", m0_rdat, 32'h1234_5678);
        check("rd_c5_err",  {31'd0, m0_err}, 32'd0);
        check("rd_c5_ack1", {31'd0, m1_ack}, 32'd0);
        check("rd_c5_regr", {31'd0, p_regr}, 32'd0);
        step(); m0_req = 0;                                           // cycle 6
        check_quiet("rd_c6");

        // console write from m1
        step(); m1_req = 1; m1_we = 1; m1_adr = 32'h0001_3000; m1_wdata = 32'h41;
        step();
        check("wr_c1_regw", {31'd0, p_regw}, 32'd1);
        repeat (3) step();                                            // cycle 4
        check("wr_c4_pack",  {31'd0, p_ack}, 32'd1);
        check("wr_c4_adr",   p_adr, 32'h0001_3000);
        check("wr_c4_wdata", p_wdata, 32'h41);
        step();                                                       // cycle 5
        check("wr_c5_ack1", {31'd0, m1_ack}, 32'd1);
        check("wr_c5_rdat", m1_rdat, 32'd0);
        check("wr_c5_ack0", {31'd0, m0_ack}, 32'd0);
        check("wr_console", {24'd0, con_chr}, 32'h41);
        step(); m1_req = 0;

        // contention right after reset
        do_reset();
        step();                                                       // cycle 0
        m0_req = 1; m0_we = 0; m0_adr = 32'h100;
        m1_req = 1; m1_we = 0; m1_adr = 32'h200;
        step();                                                       // cycle 1
        check("ct_c1_adr", p_adr, 32'h100);
        repeat (4) step();                                            // cycle 5
        check("ct_c5_ack0", {31'd0, m0_ack}, 32'd1);
        check("ct_c5_ack1", {31'd0, m1_ack}, 32'd0);
        check("ct_c5_strb", {30'd0, p_regw, p_regr}, 32'd0);
        step(); m0_req = 0;                                           // cycle 6
        check("ct_c6_strb", {30'd0, p_regw, p_regr}, 32'd0);
        check("ct_c6_busy", {31'd0, busy}, 32'd0);
        step();                                                       // cycle 7
        check("ct_c7_regr", {31'd0, p_regr}, 32'd1);
        check("ct_c7_adr",  p_adr, 32'h200);
        repeat (3) step();                                            // cycle 10
        check("ct_c10_ack1", {31'd0, m1_ack}, 32'd0);
        step();                                                       // cycle 11
        check("ct_c11_ack1", {31'd0, m1_ack}, 32'd1);
        check("ct_c11_rdat", m1_rdat, 32'h1234_5678);
        check("ct_c11_ack0", {31'd0, m0_ack}, 32'd0);
        step(); m1_req = 0;                                           // cycle 12
        step(); m0_req = 1; m1_req = 1;                               // cycle 13
        step();                                                       // cycle 14
        check("ct_c14_adr", p_adr, 32'h100);
        repeat (4) step();                                            // cycle 18
        check("ct_c18_ack0", {31'd0, m0_ack}, 32'd1);
        step(); m0_req = 0;                                           // cycle 19
        step();                                                       // cycle 20
        check("ct_c20_adr", p_adr, 32'h200);
        repeat (4) step();                                            // cycle 24
        check("ct_c24_ack1", {31'd0, m1_ack}, 32'd1);
        step(); m1_req = 0;

        // timeout with a silent peripheral, then a late ack
        do_reset();
        pen = 0;
        step(); m0_req = 1; m0_we = 0; m0_adr = 32'h300;              // cycle 0
        step();                                                       // cycle 1
        check("to_c1_regr", {31'd0, p_regr}, 32'd1);
        repeat (15) step();                                           // cycle 16
        check("to_c16_regr", {31'd0, p_regr}, 32'd1);
        check("to_c16_ack",  {31'd0, m0_ack}, 32'd0);
        step();                                                       // cycle 17
        check("to_c17_ack",  {31'd0, m0_ack}, 32'd1);
        check("to_c17_err",  {31'd0, m0_err}, 32'd1);
        check("to_c17_rdat", m0_rdat, 32'd0);
        step(); m0_req = 0;                                           // cycle 18
        step();                                                       // cycle 19
        step(); force_ack = 1;                                        // cycle 20
        step(); force_ack = 0;                                        // cycle 21
        check("to_late_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        check("to_late_busy", {31'd0, busy}, 32'd0);
        pen = 1;

        // ack coinciding with the last timeout cycle (TIMEOUT=4)
        do_reset();
        step(); m0_req = 1; m0_we = 0; m0_adr = 32'h100;              // cycle 0
        repeat (4) step();                                            // cycle 4
        check("co_c4_pack", {31'd0, p_ack4}, 32'd1);
        step();                                                       // cycle 5
        check("co_c5_ack",  {31'd0, m0_ack4}, 32'd1);
        check("co_c5_err",  {31'd0, m0_err4}, 32'd0);
        check("co_c5_rdat", m0_rdat4, 32'h1234_5678);
        step(); m0_req = 0;
        pen4 = 0;
        step(); m0_req = 1;                                           // cycle 0
        repeat (5) step();                                            // cycle 5
        check("t4_c5_ack",  {31'd0, m0_ack4}, 32'd1);
        check("t4_c5_err",  {31'd0, m0_err4}, 32'd1);
        check("t4_c5_rdat", m0_rdat4, 32'd0);
        step(); m0_req = 0;
        pen4 = 1;

        // reset in the middle of WAIT
        do_reset();
        step(); m0_req = 1; m0_we = 0; m0_adr = 32'h400;              // cycle 0
        step();                                                       // cycle 1
        step(); rst = 1;                                              // cycle 2
        step(); rst = 0; m0_req = 0;                                  // cycle 3
        check_quiet("mr");
        for (int i = 0; i < 6; i++) begin
            step();
            check("mr_noack", {30'd0, m1_ack, m0_ack}, 32'd0);
        end
        step(); m1_req = 1; m1_we = 1; m1_adr = 32'h0001_3000; m1_wdata = 32'h42;
        repeat (5) step();
        check("mr_ack1",    {31'd0, m1_ack}, 32'd1);
        check("mr_err1",    {31'd0, m1_err}, 32'd0);
        check("mr_console", {24'd0, con_chr}, 32'h42);
        step(); m1_req = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/peri_arb.md
Name: peri_arb

Overview:
- Two-master arbiter and sequencer for the single slow peripheral port (regw/regr/adr/wdata in, ack/rdat out).
- Master 0 is the core load/store unit; master 1 is the debug/console feeder.
- Grants one outstanding transaction at a time, round-robin, and holds peripheral strobes until the 1-cycle ack pulse.
- Guarantees a strobe-low gap between transactions, because the peripheral acks on a delayed strobe rising edge. Aborts hung accesses with a timeout.

Parameters:
- TIMEOUT, 16: max WAIT cycles before abort; legal 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- m0_req  in  1  master 0 request, level, held until m0_ack
- m0_we  in  1  1=write, 0=read
- m0_adr  in  32  address
- m0_wdata  in  32  write data
- m0_ack  out  1  1-cycle completion pulse
- m0_rdat  out  32  read data, valid with m0_ack
- m0_err  out  1  timeout abort, valid with m0_ack
- m1_req, m1_we, m1_adr, m1_wdata, m1_ack, m1_rdat, m1_err: same as master 0
- p_regw  out  1  peripheral write strobe
- p_regr  out  1  peripheral read strobe
- p_adr  out  32  peripheral address
- p_wdata  out  32  peripheral write data
- p_ack  in  1  peripheral ack pulse
- p_rdat  in  32  peripheral read data, valid with p_ack
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset: state=IDLE, rr pointer=m0.
  - All outputs 0: p_regw, p_regr, p_adr, p_wdata, mN_ack, mN_rdat, mN_err, busy.
  - Reset asserted mid-transaction aborts it silently; no ack is issued to any master.
- IDLE:
  - Peripheral strobes low; p_adr and p_wdata are 0.
  - If any mN_req is high: select the winner, latch its we/adr/wdata and id, clear the counter, go to WAIT.
  - Both requesting: the rr pointer decides. The pointer flips to the non-granted master on every grant.
- WAIT:
  - p_regw=latched we; p_regr=!latched we; p_adr and p_wdata show the latched values, stable for the whole state.
  - Counter increments each cycle.
  - p_ack=1: capture p_rdat (captured only for reads, else 0), err=0, go to RESP.
  - Else, if counter==TIMEOUT-1: rdat=0, err=1, go to RESP.
  - p_ack and timeout in the same cycle: ack wins, err=0.
- RESP:
  - Strobes low, p_adr and p_wdata are 0.
  - Winner's mN_ack=1 with mN_rdat and mN_err for exactly this cycle; the other master's outputs stay 0. Then go to IDLE.
- mN_rdat and mN_err are 0 whenever mN_ack=0.
- Masters drop req in the cycle after ack. A req still high in IDLE starts a new transaction.
- Strobes are low for at least 2 cycles (RESP+IDLE) between transactions, so every transaction presents a fresh rising edge.
- p_ack outside WAIT is ignored; this covers a late ack after a timeout.
- Latency with the 3-cycle-edge peripheral: req sampled in IDLE at cycle 0, WAIT in cycles 1-4, p_ack in cycle 4, mN_ack in cycle 5.
- Requests that change we/adr/wdata while pending are a protocol violation. Only values at the grant cycle are used.

Test Plan:
- Single read, m0: m0_req=1, we=0, adr=0x100 at cycle 0 -> p_regr high cycles 1-4; m0_ack=1 at cycle 5; m0_rdat=0x12345678; m0_err=0; m1_ack stays 0.
- Console write, m1: m1_req=1, we=1, adr=0x00013000, wdata=0x41 -> console prints "A"; p_adr=0x00013000 during p_ack; m1_ack at cycle 5; m1_rdat=0.
- Contention after reset, both masters request at cycle 0:
  - m0 is acked at cycle 5.
  - Strobes are low in cycles 5-6.
  - m1 WAIT starts at cycle 7 and m1 is acked at cycle 11.
  - The next simultaneous request is granted to m0 again (pointer back to m0).
- Timeout: p_ack tied 0, TIMEOUT=16, m0 read -> WAIT in cycles 1-16; m0_ack=1, m0_err=1, m0_rdat=0 at cycle 17. A p_ack injected at cycle 20 causes no mN_ack.
- Ack/timeout coincidence: TIMEOUT=4 with the standard peripheral (p_ack in the 4th WAIT cycle) -> m0_ack at cycle 5 with m0_err=0 and valid rdat.
- Reset mid-transaction: assert rst for 1 cycle in cycle 2 of WAIT -> next cycle all outputs 0 and busy=0; no mN_ack; a new m1 request completes normally.
